// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2(y, x) in Q3.29 and gain-corrected hypot in Q1.31.
// One micro-rotation per clock; ITER legal range is 1..32.
module cordic_vector #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] angle,
  output logic [31:0] magnitude,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StRotate, StScale, StDone} state_e;

  localparam logic [4:0]         LastIter = 5'(ITER - 1);
  localparam logic signed [31:0] HalfPi   = 32'sh3243F6A9;
  localparam logic signed [65:0] InvGain  = 66'sh4DBA7700;
  localparam logic signed [65:0] MagMax   = 66'sh7FFFFFFF;

  // atan(2^-i) as a Q1.31 table, returned in Q3.29
  function automatic logic signed [31:0] atan_q329(input logic [4:0] i);
    logic [31:0] t;
    case (i)
      5'd0:    t = 32'h6487ED51;
      5'd1:    t = 32'h3B58CE0B;
      5'd2:    t = 32'h1F5B75F9;
      5'd3:    t = 32'h0FEADD4B;
      5'd4:    t = 32'h07FD56ED;
      5'd5:    t = 32'h03FFAAB7;
      5'd6:    t = 32'h01FFF555;
      5'd7:    t = 32'h00FFFEAB;
      5'd8:    t = 32'h007FFFD5;
      5'd9:    t = 32'h003FFFFB;
      5'd10:   t = 32'h001FFFFF;
      default: t = 32'h00000001 << (5'd31 - i);
    endcase
    return $signed(t >> 2);
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic signed [33:0] x_q, x_d, y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [31:0]        angle_q, angle_d, mag_q, mag_d;

  logic signed [33:0] x_ext, y_ext, x_sh, y_sh;
  logic signed [31:0] a_i;
  logic signed [65:0] x_wide, prod_sh;
  logic [31:0]        mag_sat;
  logic               at_origin;

  always_comb begin
    x_ext     = {{2{x_in[31]}}, x_in};
    y_ext     = {{2{y_in[31]}}, y_in};
    x_sh      = x_q >>> iter_q;
    y_sh      = y_q >>> iter_q;
    a_i       = atan_q329(iter_q);
    // A zero vector has no direction; freezing z keeps its angle at 0
    at_origin = (x_q == 34'sd0) && (y_q == 34'sd0);
    x_wide    = {{32{x_q[33]}}, x_q};
    prod_sh   = (x_wide * InvGain) >>> 31;
    if (prod_sh < 66'sd0) begin
      mag_sat = 32'h0;
    end else if (prod_sh > MagMax) begin
      mag_sat = 32'h7FFFFFFF;
    end else begin
      mag_sat = prod_sh[31:0];
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Fold the left half-plane into the right so the iterations converge
          if (!x_in[31]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 32'sd0;
          end else if (!y_in[31]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = HalfPi;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -HalfPi;
          end
          iter_d  = 5'd0;
          state_d = StRotate;
        end
      end
      StRotate: begin
        if (!y_q[33]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = at_origin ? z_q : z_q + a_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - a_i;
        end
        if (iter_q == LastIter) begin
          iter_d  = 5'd0;
          state_d = StScale;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end
      StScale: begin
        angle_d = z_q;
        mag_d   = mag_sat;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      iter_q  <= 5'd0;
      x_q     <= 34'sd0;
      y_q     <= 34'sd0;
      z_q     <= 32'sd0;
      angle_q <= 32'h0;
      mag_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign angle     = angle_q;
  assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: directed vectors, handshake timing, mid-job reset.
module tb_cordic_vector;

  localparam int unsigned ITER = 32;
  localparam longint AngTol = 64;
  localparam longint MagTol = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] angle;
  logic [31:0] magnitude;
  logic        out_valid;
  logic        out_ready = 1'b1;

  cordic_vector #(.ITER(ITER)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .magnitude (magnitude),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ang;
    logic [31:0] mag;
    bit          half;  // only |angle| <= pi/2 is required
    int          id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Directed vectors: x, y, expected angle (Q3.29), expected magnitude (Q1.31)
  localparam int NV = 11;
  logic [31:0] vx[NV] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h00000000,
                          32'h00000000, 32'h40000000, 32'h20000000, 32'h7FFFFFFF,
                          32'h80000000, 32'h80000000, 32'h00000000};
  logic [31:0] vy[NV] = '{32'h00000000, 32'h40000000, 32'h00000000, 32'hC0000000,
                          32'h40000000, 32'hC0000000, 32'h40000000, 32'h7FFFFFFF,
                          32'h00000000, 32'h80000000, 32'h00000000};
  logic [31:0] va[NV] = '{32'h00000000, 32'h1921FB54, 32'h6487ED51, 32'hCDBC0957,
                          32'h3243F6A9, 32'hE6DE04AC, 32'h236DC326, 32'h1921FB54,
                          32'h6487ED51, 32'hB49A0E04, 32'h00000000};
  logic [31:0] vm[NV] = '{32'h40000000, 32'h5A82799A, 32'h40000000, 32'h40000000,
                          32'h40000000, 32'h5A82799A, 32'h478DDE6E, 32'h7FFFFFFF,
                          32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000};

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_near(input string name, input longint got, input longint want,
                            input longint tol);
    longint d;
    d = got - want;
    if (d < 0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d tol=%0d", name, got, want, tol);
    end
  endtask

  // Monitor: a result transfers on a clock edge with out_valid && out_ready
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output got angle=%h mag=%h want none", angle, magnitude);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.half)
          check_near($sformatf("vec%0d_angle", mon_e.id), longint'($signed(angle)), 0,
                     longint'(32'h3243F6A9) + AngTol);
        else
          check_near($sformatf("vec%0d_angle", mon_e.id), longint'($signed(angle)),
                     longint'($signed(mon_e.ang)), AngTol);
        check_near($sformatf("vec%0d_mag", mon_e.id), longint'(magnitude),
                   longint'(mon_e.mag), MagTol);
      end
    end
  end

  task automatic send(input int id);
    int n;
    @(posedge clk);
    #1;
    x_in     = vx[id];
    y_in     = vy[id];
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout vec%0d got in_ready=0 want 1", id);
    end else begin
      sb.push_back('{ang: va[id], mag: vm[id], half: (id == NV - 1), id: id});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_queue_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edges;
    bit          seen;
    logic [31:0] hold_a, hold_m;

    #2 reset = 1'b0;
    #10;
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_angle", angle, 32'd0);
    check_eq("reset_magnitude", magnitude, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed vectors back to back with out_ready held high
    for (int i = 0; i < NV; i++) send(i);
    drain();

    // Latency, hold under back-pressure, in_valid ignored while busy
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    x_in     = vx[1];
    y_in     = vy[1];
    in_valid = 1'b1;
    sb.push_back('{ang: va[1], mag: vm[1], half: 1'b0, id: 100});
    edges = 0;
    @(posedge clk);
    #1;
    edges++;
    in_valid = 1'b0;
    check_eq("busy_after_accept", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      edges++;
    end
    x_in     = vx[0];
    y_in     = vy[0];
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      edges++;
    end
    in_valid = 1'b0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    // Counted in edges from the cycle in_valid was raised
    check_eq("latency", 32'(edges), 32'(ITER + 2));
    hold_a = angle;
    hold_m = magnitude;
    repeat (10) begin
      @(posedge clk);
      #1;
      check_eq("hold_handshake", {30'd0, in_ready, out_valid}, 32'd1);
      check_eq("hold_angle", angle, hold_a);
      check_eq("hold_magnitude", magnitude, hold_m);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_out_valid", 32'(out_valid), 32'd0);
    check_eq("release_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("ignored_pulse_no_output", 32'(seen), 32'd0);
    check_eq("ignored_pulse_queue", 32'(sb.size()), 32'd0);

    // Reset in the middle of ROTATE discards the job
    @(posedge clk);
    #1;
    x_in     = vx[7];
    y_in     = vy[7];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("midreset_out_valid", 32'(out_valid), 32'd0);
    check_eq("midreset_in_ready", 32'(in_ready), 32'd1);
    check_eq("midreset_angle", angle, 32'd0);
    check_eq("midreset_magnitude", magnitude, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    send(0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
